// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC job sequencer.
//   - mac_seq_state_t : controller FSM state encoding
//   - DATA_W / ACC_W / LEN_W : default operand, accumulator and pair-count widths
//   - MAC_LAT : default MAC pipeline latency (mac_en beat -> visible on mac_acc)
//   - drain_cycles() : length of the post-stream wait for a given MAC latency
package mac_seq_pkg;

  localparam int DATA_W  = 16;
  localparam int ACC_W   = 32;
  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } mac_seq_state_t;

  // The last operand leaves the controller's operand register one cycle after
  // its handshake, then needs mac_lat more cycles inside the MAC.
  function automatic int drain_cycles(input int mac_lat);
    return mac_lat + 1;
  endfunction

endpackage

// File: rtl/mac_seq_drain_timer.sv
// Loadable down-counter that produces a one-cycle registered done pulse.
// Loading value N makes done high in the (N+1)-th cycle after the load edge,
// so a wait of C cycles is obtained by loading C-1.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset
//   load     in  start a new count
//   load_val in  W  count start value
//   done     out 1-cycle pulse in the final cycle of the wait
module mac_seq_drain_timer
  import mac_seq_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_r;

  // Count down from the loaded value; done marks the cycle the count is zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
      done    <= 1'b0;
    end else if (load) begin
      count_r <= load_val;
      done    <= (load_val == {W{1'b0}});
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - W'(1);
      done    <= (count_r == W'(1));
    end else begin
      count_r <= count_r;
      done    <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the pipelined 16x16->32 MAC datapath.
// Accepts a dot-product command (pair count), clears the MAC, streams operand
// pairs into it, waits out the MAC latency and returns the final accumulator.
// Build option: define MAC_SEQ_PERF_EN to build the saturating stall counter
// behind perf_stall; otherwise perf_stall is a constant zero.
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   cmd_valid/ready/len  command handshake, len = number of pairs (0 legal)
//   op_valid/ready/a/b   operand pair handshake (unsigned operands)
//   mac_clr, mac_en      MAC accumulator clear / operand beat valid
//   mac_a, mac_b         registered operands to the MAC
//   mac_acc              MAC accumulator output
//   res_valid/ready/data result handshake, data = captured accumulator
//   busy                 controller not idle
//   perf_stall           STREAM cycles with op_valid low (saturating)
module mac_seq_ctrl #(
  parameter int DATA_W  = mac_seq_pkg::DATA_W,
  parameter int ACC_W   = mac_seq_pkg::ACC_W,
  parameter int LEN_W   = mac_seq_pkg::LEN_W,
  parameter int MAC_LAT = mac_seq_pkg::MAC_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              busy,
  output logic [15:0]       perf_stall
);

  import mac_seq_pkg::*;

  localparam int DRAIN_CYC = drain_cycles(MAC_LAT);
  localparam int TMR_W     = $clog2(DRAIN_CYC + 1);
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYC - 1);

  mac_seq_state_t   state_r;
  logic [LEN_W-1:0] remaining_r;
  logic             op_hs_s;
  logic             drain_load_s;
  logic             drain_done_s;

  assign op_hs_s = op_valid && op_ready && (state_r == ST_STREAM);

  // Start the drain wait on the edge that enters DRAIN (from CLEAR or last beat).
  always_comb begin
    drain_load_s = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        if (remaining_r == {LEN_W{1'b0}}) begin
          drain_load_s = 1'b1;
        end else begin
          drain_load_s = 1'b0;
        end
      end
      ST_STREAM: begin
        if (op_hs_s && (remaining_r == LEN_W'(1))) begin
          drain_load_s = 1'b1;
        end else begin
          drain_load_s = 1'b0;
        end
      end
      default: drain_load_s = 1'b0;
    endcase
  end

  mac_seq_drain_timer #(
    .W (TMR_W)
  ) u_drain_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (drain_load_s),
    .load_val (DRAIN_LOAD),
    .done     (drain_done_s)
  );

  // Controller FSM; every output is registered alongside the state change
  // so it is valid in the same cycle as the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      remaining_r <= {LEN_W{1'b0}};
      cmd_ready   <= 1'b0;
      op_ready    <= 1'b0;
      mac_clr     <= 1'b0;
      mac_en      <= 1'b0;
      mac_a       <= {DATA_W{1'b0}};
      mac_b       <= {DATA_W{1'b0}};
      res_valid   <= 1'b0;
      res_data    <= {ACC_W{1'b0}};
      busy        <= 1'b0;
    end else begin
      // Single-cycle strobes; only the branches below raise them.
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            remaining_r <= cmd_len;
            state_r     <= ST_CLEAR;
            cmd_ready   <= 1'b0;
            mac_clr     <= 1'b1;
            busy        <= 1'b1;
          end else begin
            // Covers the first idle cycle after reset.
            cmd_ready <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (remaining_r != {LEN_W{1'b0}}) begin
            state_r  <= ST_STREAM;
            op_ready <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_STREAM: begin
          if (op_hs_s) begin
            mac_a       <= op_a;
            mac_b       <= op_b;
            mac_en      <= 1'b1;
            remaining_r <= remaining_r - LEN_W'(1);
            if (remaining_r == LEN_W'(1)) begin
              state_r  <= ST_DRAIN;
              op_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done_s) begin
            res_data  <= mac_acc;
            res_valid <= 1'b1;
            state_r   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cmd_ready <= 1'b0;
          op_ready  <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAC_SEQ_PERF_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of STREAM cycles in which the producer had nothing to offer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 16'd0;
    end else if ((state_r == ST_STREAM) && !op_valid && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign perf_stall = stall_cnt_r;
`else
  assign perf_stall = 16'd0;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl (MAC_LAT = 2). A behavioural MAC
// datapath drives mac_acc; expected results come from summing products with
// 32-bit wrap, and expected result latency from len + stalls + MAC_LAT + 3.
module tb_mac_seq_ctrl;

  localparam int DATA_W  = 16;
  localparam int ACC_W   = 32;
  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 2;

`ifdef MAC_SEQ_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a, op_b;
  logic              mac_clr, mac_en;
  logic [DATA_W-1:0] mac_a, mac_b;
  logic [ACC_W-1:0]  mac_acc;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              busy;
  logic [15:0]       perf_stall;

  always #5 clk = ~clk;

  mac_seq_ctrl #(
    .DATA_W (DATA_W), .ACC_W (ACC_W), .LEN_W (LEN_W), .MAC_LAT (MAC_LAT)
  ) dut (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_len (cmd_len),
    .op_valid (op_valid), .op_ready (op_ready), .op_a (op_a), .op_b (op_b),
    .mac_clr (mac_clr), .mac_en (mac_en), .mac_a (mac_a), .mac_b (mac_b),
    .mac_acc (mac_acc),
    .res_valid (res_valid), .res_ready (res_ready), .res_data (res_data),
    .busy (busy), .perf_stall (perf_stall)
  );

  // Behavioural MAC: a beat (or clear) in cycle c shows on mac_acc in cycle
  // c + MAC_LAT. Written for MAC_LAT >= 2. It has no reset, like the real
  // datapath; the controller's clear is what empties it.
  bit        p_clr  [MAC_LAT-1];
  bit        p_en   [MAC_LAT-1];
  bit [31:0] p_prod [MAC_LAT-1];
  bit [31:0] acc_m;
  assign mac_acc = acc_m;

  always @(posedge clk) begin
    if (p_clr[MAC_LAT-2])     acc_m <= 32'd0;
    else if (p_en[MAC_LAT-2]) acc_m <= acc_m + p_prod[MAC_LAT-2];
    for (int i = MAC_LAT - 2; i > 0; i--) begin
      p_clr[i]  <= p_clr[i-1];
      p_en[i]   <= p_en[i-1];
      p_prod[i] <= p_prod[i-1];
    end
    p_clr[0]  <= mac_clr;
    p_en[0]   <= mac_en;
    p_prod[0] <= 32'(mac_a) * 32'(mac_b);
  end

  int errors = 0;
  int checks = 0;
  int perf_exp = 0;

  logic [15:0] ja [16];
  logic [15:0] jb [16];
  int          jgap [16];

  typedef struct packed {
    logic [7:0]  len;
    logic [15:0] a0, b0, a1, b1, a2, b2;
    logic [3:0]  g1;
    logic [3:0]  hold;
    logic        noise;
    logic        hold_cmd;
    logic [31:0] exp_res;
    logic [7:0]  exp_lat;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int len, input int a0, input int b0, input int a1,
                              input int b1, input int a2, input int b2, input int g1,
                              input int hold, input bit noise, input bit hold_cmd,
                              input logic [31:0] exp_res, input int exp_lat);
    vec_t v;
    v.len = 8'(len);   v.a0 = 16'(a0); v.b0 = 16'(b0); v.a1 = 16'(a1); v.b1 = 16'(b1);
    v.a2 = 16'(a2);    v.b2 = 16'(b2); v.g1 = 4'(g1);  v.hold = 4'(hold);
    v.noise = noise;   v.hold_cmd = hold_cmd;
    v.exp_res = exp_res; v.exp_lat = 8'(exp_lat);
    return v;
  endfunction

  // One job, driven cycle by cycle from the negedge. ja/jb hold the pairs and
  // jgap[i] the number of idle STREAM cycles before pair i. abort_after > 0
  // pulses rst once that many pairs have been handed over.
  task automatic run_job(input string nm, input int len, input int hold, input bit noise,
                         input bit hold_cmd, input int abort_after,
                         input logic [31:0] exp_res, input int exp_lat);
    int cyc, beat, gap_left, hold_left, clr_cnt, en_cnt, viol, lat, wait_cnt, gaps;
    bit seen_res, finished;
    logic [31:0] held;
    cyc = 0; beat = 0; hold_left = hold; clr_cnt = 0; en_cnt = 0; viol = 0;
    lat = -1; wait_cnt = 0; gaps = 0; seen_res = 1'b0; finished = 1'b0; held = 32'd0;
    for (int i = 0; i < len; i++) gaps += jgap[i];
    gap_left = (len > 0) ? jgap[0] : 0;

    cmd_len   = LEN_W'(len);
    cmd_valid = 1'b1;
    op_valid  = noise;
    op_a      = 16'($urandom);
    op_b      = 16'($urandom);
    while (!cmd_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!cmd_ready) begin
      check({nm, "_accept_timeout"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end

    @(negedge clk);
    cyc = 1;
    if (!hold_cmd) cmd_valid = 1'b0;
    cmd_len = LEN_W'($urandom);
    while (!finished && cyc < 2000) begin
      if (mac_clr) clr_cnt++;
      if (mac_en) en_cnt++;
      if (mac_clr && mac_en) viol++;
      if (cmd_ready || !busy) viol++;

      if (abort_after > 0 && beat == abort_after) begin
        rst = 1'b1; op_valid = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        check({nm, "_rst_ctl"}, {27'd0, cmd_ready, op_ready, mac_clr, mac_en, busy}, 32'd0);
        check({nm, "_rst_ab"}, {mac_a, mac_b}, 32'd0);
        check({nm, "_rst_res"}, {31'd0, res_valid}, 32'd0);
        check({nm, "_rst_data"}, res_data, 32'd0);
        check({nm, "_rst_perf"}, 32'(perf_stall), 32'd0);
        rst = 1'b0;
        perf_exp = 0;
        viol = 0;
        repeat (4) begin
          @(negedge clk);
          if (res_valid || busy) viol++;
        end
        check({nm, "_rst_no_result"}, 32'(viol), 32'd0);
        check({nm, "_rst_cmd_ready"}, 32'(cmd_ready), 32'd1);
        return;
      end

      if (res_valid) begin
        if (!seen_res) begin
          seen_res = 1'b1;
          lat = cyc;
          held = res_data;
        end else if (res_data !== held) begin
          viol++;
        end
        if (op_ready) viol++;
        if (hold_left > 0) begin
          res_ready = 1'b0;
          hold_left--;
        end else begin
          res_ready = 1'b1;
          finished = 1'b1;
          cmd_valid = 1'b0;
        end
      end else begin
        res_ready = noise;
      end

      if (op_ready && beat < len) begin
        if (gap_left > 0) begin
          op_valid = 1'b0;
          gap_left--;
        end else begin
          op_valid = 1'b1;
          op_a = ja[beat];
          op_b = jb[beat];
          beat++;
          gap_left = (beat < len) ? jgap[beat] : 0;
        end
      end else begin
        op_valid = noise;
        op_a = 16'($urandom);
        op_b = 16'($urandom);
      end
      @(negedge clk);
      cyc++;
    end

    res_ready = 1'b0;
    op_valid  = 1'b0;
    cmd_valid = 1'b0;
    perf_exp += gaps;
    check({nm, "_finished"}, 32'(finished), 32'd1);
    check({nm, "_res_data"}, held, exp_res);
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_clr_beats"}, 32'(clr_cnt), 32'd1);
    check({nm, "_en_beats"}, 32'(en_cnt), 32'(len));
    check({nm, "_protocol"}, 32'(viol), 32'd0);
    check({nm, "_idle_after"}, {29'd0, cmd_ready, busy, res_valid}, 32'b100);
    check({nm, "_perf"}, 32'(perf_stall),
          PERF_ON ? 32'((perf_exp > 65535) ? 65535 : perf_exp) : 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          rlen, rgap, rhold;
    logic [31:0] rexp;

    rst = 1'b1; cmd_valid = 1'b0; cmd_len = 8'd0; op_valid = 1'b0;
    op_a = 16'd0; op_b = 16'd0; res_ready = 1'b0;

    // len, pairs, gap before pair 2, DONE hold, noise, hold cmd, result, latency
    tbl[0] = mk(3, 2, 3, 4, 5, 10, 10, 0, 0, 1'b0, 1'b0, 32'd126, 8);
    tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 32'd0, 5);
    tbl[2] = mk(3, 2, 3, 4, 5, 10, 10, 2, 0, 1'b0, 1'b0, 32'd126, 10);
    tbl[3] = mk(3, 2, 3, 4, 5, 10, 10, 0, 4, 1'b0, 1'b0, 32'd126, 8);
    tbl[4] = mk(1, 7, 8, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 32'd56, 6);
    tbl[5] = mk(3, 2, 3, 4, 5, 10, 10, 0, 0, 1'b1, 1'b1, 32'd126, 8);
    tbl[6] = mk(2, 65535, 65535, 65535, 65535, 0, 0, 0, 0, 1'b0, 1'b0, 32'hFFFC0002, 7);

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_ctl", {27'd0, op_ready, mac_clr, mac_en, res_valid, busy}, 32'd0);
    check("rst_mac_ab", {mac_a, mac_b}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_perf", 32'(perf_stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      ja[0] = tbl[i].a0; jb[0] = tbl[i].b0;
      ja[1] = tbl[i].a1; jb[1] = tbl[i].b1;
      ja[2] = tbl[i].a2; jb[2] = tbl[i].b2;
      jgap[0] = 0; jgap[1] = int'(tbl[i].g1); jgap[2] = 0;
      run_job($sformatf("vec%0d", i), int'(tbl[i].len), int'(tbl[i].hold), tbl[i].noise,
              tbl[i].hold_cmd, 0, tbl[i].exp_res, int'(tbl[i].exp_lat));
    end

    // Reset one cycle after the first beat, then a fresh job must be clean.
    ja[0] = 16'd9; jb[0] = 16'd9; ja[1] = 16'd3; jb[1] = 16'd3; ja[2] = 16'd4; jb[2] = 16'd4;
    jgap[0] = 0; jgap[1] = 0; jgap[2] = 0;
    run_job("abort", 3, 0, 1'b0, 1'b0, 1, 32'd0, 0);
    ja[0] = 16'd1; jb[0] = 16'd1; ja[1] = 16'd2; jb[1] = 16'd2;
    run_job("after_abort", 2, 0, 1'b0, 1'b0, 0, 32'd5, 7);

    for (int j = 0; j < 25; j++) begin
      rlen = $urandom_range(0, 12);
      rexp = 32'd0;
      rgap = 0;
      for (int k = 0; k < rlen; k++) begin
        ja[k] = 16'($urandom);
        jb[k] = 16'($urandom);
        jgap[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        rexp = rexp + 32'(ja[k]) * 32'(jb[k]);
        rgap += jgap[k];
      end
      rhold = $urandom_range(0, 3);
      run_job($sformatf("rand%0d", j), rlen, rhold, 1'($urandom), 1'($urandom), 0,
              rexp, rlen + rgap + MAC_LAT + 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
